// File: rtl/ifm_stream_reader_if.sv
// Preload and stream bundle for the IFM stream reader.
// The master side drives the preload, start and consumer-ready signals; the slave side is the reader.
interface ifm_stream_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] in;
    logic              start;
    logic [ADDR_W-1:0] base_adr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] stride;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output we, adr, in, start, base_adr, count, stride, out_ready,
        input  out_data, out_valid, busy, done
    );

    modport slave (
        input  we, adr, in, start, base_adr, count, stride, out_ready,
        output out_data, out_valid, busy, done
    );
endinterface

// File: rtl/ifm_stream_reader.sv
// Input-feature-map store with a strided valid/ready streaming read port.
// Reads are issued only when a 2-entry skid FIFO is guaranteed to have room for them.
module ifm_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    ifm_stream_reader_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] issue_adr;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   accepted;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        fifo_occ;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2:0]        credit;

    // A word popped this cycle frees its slot in time for a read issued now, which keeps
    // the stream at one word per cycle without ever overfilling the FIFO.
    always_comb begin
        push   = rd_valid;
        pop    = (fifo_occ != 2'd0) && bus.out_ready;
        credit = {1'b0, fifo_occ} + {2'b00, rd_valid} - {2'b00, pop};
        issue  = (state == RUN) && (credit < 3'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_adr <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            issued    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        issue_adr <= bus.base_adr;
                        stride_q  <= bus.stride;
                        count_q   <= bus.count;
                        issued    <= '0;
                        state     <= (bus.count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_adr <= issue_adr + stride_q;
                        issued    <= issued + ONE;
                        if (issued + ONE == count_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((accepted == count_q) && (fifo_occ == 2'd0))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            accepted <= '0;
        else if ((state == IDLE) && bus.start)
            accepted <= '0;
        else if (pop)
            accepted <= accepted + ONE;
    end

    // Read-first store: a write and a read of the same address in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (bus.we)
            mem[bus.adr] <= bus.in;
        if (issue)
            rd_data <= mem[issue_adr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_valid <= 1'b0;
        else
            rd_valid <= issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                fifo_mem[i] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_occ <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_occ <= fifo_occ + 2'd1;
                2'b01:   fifo_occ <= fifo_occ - 2'd1;
                default: fifo_occ <= fifo_occ;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = (fifo_occ != 2'd0);
        bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : '0;
        bus.busy      = (state == RUN) || (state == DRAIN);
        bus.done      = (state == DONE);
    end
endmodule

// File: tb/tb_ifm_stream_reader.sv
// Directed bench for ifm_stream_reader: preload, strided streams, backpressure, abort and
// read-first collision, each compared against hand-computed expectations.
module tb_ifm_stream_reader;
    logic clk;
    logic rst;

    ifm_stream_reader_if #(.DATA_W(32), .ADDR_W(9)) bus ();

    ifm_stream_reader #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checkCount;
    int          passCount;
    logic [31:0] model [512];
    logic [31:0] got [$];
    int          firstK;
    int          doneK;
    logic        doneAfter;
    logic [8:0]  wAdr;
    logic [31:0] wData;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Start is sampled at the next rising edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [8:0] base, input logic [9:0] cnt, input logic [8:0] strd);
        bus.start    = 1'b1;
        bus.base_adr = base;
        bus.count    = cnt;
        bus.stride   = strd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycle k=0 is the cycle right after the start edge.
    task automatic collectWords(input int maxCycles, input int readyMode, input int restartAt, input int writeAt);
        logic [31:0] prevData;
        logic        prevStall;
        bit          seen;
        got.delete();
        firstK    = -1;
        doneK     = -1;
        prevStall = 1'b0;
        prevData  = '0;
        seen      = 1'b0;
        for (int k = 0; k < maxCycles && !seen; k++) begin
            bus.out_ready = (readyMode == 0) ? 1'b1 : ((k % 3) == 0);
            bus.we        = (k == writeAt);
            bus.adr       = wAdr;
            bus.in        = wData;
            bus.start     = (k == restartAt);
            if (k == restartAt) begin
                bus.base_adr = 9'd100;
                bus.count    = 10'd2;
                bus.stride   = 9'd1;
            end
            if (prevStall) begin
                checkOutput("stall_valid", bus.out_valid, 1);
                checkOutput("stall_data", bus.out_data, prevData);
            end
            if (bus.out_valid && firstK < 0)
                firstK = k;
            if (bus.out_valid && bus.out_ready)
                got.push_back(bus.out_data);
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            if (bus.done) begin
                doneK = k;
                seen  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.we        = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        doneAfter     = bus.done;
        if (!seen)
            checkOutput("done_timeout", 0, 1);
    endtask

    task automatic checkRun(input string tag, input int base, input int cnt, input int strd, input bit timed);
        logic [31:0] obs;
        logic [31:0] exp;
        checkOutput({tag, "_len"}, got.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            exp = model[(base + i * strd) % 512];
            obs = (i < got.size()) ? got[i] : ~exp;
            checkOutput($sformatf("%s_w%0d", tag, i), obs, exp);
        end
        checkOutput({tag, "_first_valid"}, firstK, 2);
        if (timed)
            checkOutput({tag, "_done_cycle"}, doneK, cnt + 3);
        checkOutput({tag, "_done_width"}, doneAfter, 0);
    endtask

    initial begin
        int doneSeen;
        int busySeen;
        checkCount    = 0;
        passCount     = 0;
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.adr       = '0;
        bus.in        = '0;
        bus.start     = 1'b0;
        bus.base_adr  = '0;
        bus.count     = '0;
        bus.stride    = '0;
        bus.out_ready = 1'b1;
        wAdr          = 9'd0;
        wData         = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_data", bus.out_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 512; i++) begin
            bus.we   = 1'b1;
            bus.adr  = 9'(i);
            bus.in   = 32'(i);
            model[i] = 32'(i);
            @(posedge clk);
            #1;
        end
        bus.we = 1'b0;

        // Basic run, then wrap-around and stride 0.
        applyStimulus(9'd0, 10'd8, 9'd1);
        checkOutput("t1_busy", bus.busy, 1);
        collectWords(100, 0, -1, -1);
        checkRun("t1", 0, 8, 1, 1);

        applyStimulus(9'd510, 10'd4, 9'd1);
        collectWords(100, 0, -1, -1);
        checkRun("t2_wrap", 510, 4, 1, 1);
        checkOutput("t2_wrap_lit", (got.size() > 2) ? got[2] : 32'hFFFF_FFFF, 0);

        applyStimulus(9'd5, 10'd3, 9'd0);
        collectWords(100, 0, -1, -1);
        checkRun("t2_stride0", 5, 3, 0, 1);

        // Backpressure with ready pattern 1,0,0 repeating.
        applyStimulus(9'd0, 10'd8, 9'd1);
        collectWords(200, 1, -1, -1);
        checkRun("t3", 0, 8, 1, 0);

        // Zero-length stream, then a start issued while busy.
        applyStimulus(9'd0, 10'd0, 9'd1);
        checkOutput("t4_done", bus.done, 1);
        checkOutput("t4_busy", bus.busy, 0);
        checkOutput("t4_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("t4_done_after", bus.done, 0);
        checkOutput("t4_valid_after", bus.out_valid, 0);
        applyStimulus(9'd0, 10'd4, 9'd1);
        collectWords(100, 0, 1, -1);
        checkRun("t4_ignore", 0, 4, 1, 1);

        // Abort after three words accepted.
        applyStimulus(9'd0, 10'd8, 9'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5_pre_valid", bus.out_valid, 1);
        checkOutput("t5_pre_data", bus.out_data, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", bus.out_valid, 0);
        checkOutput("t5_rst_busy", bus.busy, 0);
        checkOutput("t5_rst_done", bus.done, 0);
        @(negedge clk);
        rst      = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            doneSeen += int'(bus.done);
            busySeen += int'(bus.busy);
        end
        checkOutput("t5_no_done", doneSeen, 0);
        checkOutput("t5_idle", busySeen, 0);
        applyStimulus(9'd0, 10'd2, 9'd1);
        collectWords(100, 0, -1, -1);
        checkRun("t5_restart", 0, 2, 1, 1);

        // Write to address 5 in the same cycle it is read.
        wAdr  = 9'd5;
        wData = 32'hDEAD_BEEF;
        applyStimulus(9'd0, 10'd8, 9'd1);
        collectWords(100, 0, -1, 5);
        checkRun("t6_old", 0, 8, 1, 1);
        model[5] = 32'hDEAD_BEEF;
        applyStimulus(9'd0, 10'd8, 9'd1);
        collectWords(100, 0, -1, -1);
        checkRun("t6_new", 0, 8, 1, 1);
        checkOutput("t6_new_lit", (got.size() > 5) ? got[5] : 32'd0, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule
